count_1s: RTL and testbench

Population-count block. It counts the number of '1' bits in a DATA_W-bit input word and presents the count on a registered output. It is used wherever a bit-weight of a status/data word is needed, e.g. error-bit tallies and occupancy masks. The block is a pure datapath: no handshake, and it accepts a new word every clock.

---
 rtl/count_1s_pkg.sv | 18 +
 rtl/count_1s_popcount_tree.sv | 50 +++++
 rtl/count_1s.sv | 50 +++++
 tb/tb_count_1s.sv | 137 +++++++++++++
 4 files changed

// File: rtl/count_1s_pkg.sv
// ---------------------------------------------------------------------------
// count_1s_pkg
//
// Shared constants and helpers for the population-count block.
//
// Contents:
//   cnt_width(data_w) : number of bits needed to hold any value 0..data_w.
//                       This is the width of the count result, so a word
//                       of all ones never overflows the count.
// ---------------------------------------------------------------------------
package count_1s_pkg;

  // A count of data_w ones must fit, hence data_w+1 distinct values
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/count_1s_popcount_tree.sv
// ---------------------------------------------------------------------------
// popcount_tree
//
// Combinational pairwise adder tree that counts the '1' bits of a word.
//
// Parameters:
//   DATA_W : width of the input word (>= 1)
//   CNT_W  : width of the count (defaults to cnt_width(DATA_W))
//
// Ports:
//   data  input  [DATA_W-1:0]  word whose set bits are counted
//   count output [CNT_W-1:0]   number of set bits in data
// ---------------------------------------------------------------------------
module popcount_tree
  import count_1s_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = cnt_width(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count
);

  // Leaves are padded up to a power of two so the tree stays balanced.
  // The padding leaves are tied to zero and cost nothing after synthesis.
  localparam int LEVELS = $clog2(DATA_W);
  localparam int LEAVES = 1 << LEVELS;

  // Heap-ordered node array: node 1 is the root, node i has children
  // 2i and 2i+1, and the leaves occupy LEAVES..2*LEAVES-1. Every node is
  // CNT_W wide; a partial sum never exceeds DATA_W, so it cannot overflow.
  logic [CNT_W-1:0] node [1:2*LEAVES-1];

  // Each input bit becomes a zero-extended 1-bit value at a leaf
  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < DATA_W) begin : g_bit
      assign node[LEAVES+i] = CNT_W'(data[i]);
    end else begin : g_pad
      assign node[LEAVES+i] = '0;
    end
  end

  // Internal nodes add their two children
  for (genvar i = 1; i < LEAVES; i++) begin : g_sum
    assign node[i] = node[2*i] + node[2*i+1];
  end

  assign count = node[1];

endmodule

// File: rtl/count_1s.sv
// ---------------------------------------------------------------------------
// count_1s
//
// Registered population count: o_count holds the number of '1' bits that
// i_data carried at the previous rising clock edge. One word per cycle,
// latency of exactly one cycle, no handshake.
//
// Parameters:
//   DATA_W : width of the input word (>= 1)
//   CNT_W  : width of the count output (defaults to clog2(DATA_W+1))
//
// Ports:
//   i_clk   input  1         system clock, rising edge
//   i_rst   input  1         synchronous active-high reset, clears o_count
//   i_data  input  DATA_W    word whose set bits are counted
//   o_count output CNT_W     registered count of set bits
// ---------------------------------------------------------------------------
module count_1s
  import count_1s_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = cnt_width(DATA_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data,
  output logic [CNT_W-1:0]  o_count
);

  logic [CNT_W-1:0] count_comb;

  popcount_tree #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_tree (
    .data  (i_data),
    .count (count_comb)
  );

  // Output register. Reset takes priority, so a word presented while reset
  // is asserted is dropped rather than counted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_count <= '0;
    end else begin
      o_count <= count_comb;
    end
  end

endmodule

// File: tb/tb_count_1s.sv
// ---------------------------------------------------------------------------
// tb_count_1s
//
// Bench for count_1s (DATA_W=8). Stimulus is applied on the falling edge and
// the count expected after the following rising edge is queued. A separate
// monitor samples o_count shortly after every rising edge and compares it
// against the head of the queue.
// ---------------------------------------------------------------------------
module tb_count_1s;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  logic              i_clk;
  logic              i_rst;
  logic [DATA_W-1:0] i_data;
  logic [CNT_W-1:0]  o_count;

  int    total_checks;
  int    bad_checks;
  int    exp_q [$];
  string tag_q [$];

  count_1s #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .o_count (o_count)
  );

  // Free-running 10 ns clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference bit counter, written as a plain loop over the word
  function automatic int ref_pop(input logic [DATA_W-1:0] v);
    int n;
    n = 0;
    for (int b = 0; b < DATA_W; b++) begin
      if (v[b]) n++;
    end
    return n;
  endfunction

  // Drive one cycle of input on the falling edge and queue the count that
  // must appear after the next rising edge
  task automatic applyStimulus(input logic rst, input logic [DATA_W-1:0] data,
                               input int exp, input string tag);
    @(negedge i_clk);
    i_rst  = rst;
    i_data = data;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  // Pop one expectation and compare it with the sampled output
  task automatic checkOutput();
    int    exp;
    string tag;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    total_checks++;
    if (int'(o_count) != exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: o_count=%0d expected=%0d at %0t", tag, o_count, exp, $time);
    end
  endtask

  // Monitor: one output per cycle, sampled 1 ns after the rising edge
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (exp_q.size() > 0) checkOutput();
    end
  end

  // Directed stimulus with hand-computed expected counts
  initial begin
    logic [DATA_W-1:0] vec_data [9];
    int                vec_exp  [9];
    logic [DATA_W-1:0] sweep;
    int                drain;

    total_checks = 0;
    bad_checks   = 0;
    i_rst        = 1'b1;
    i_data       = 8'hFF;

    vec_data = '{8'h00, 8'hFF, 8'h80, 8'h01, 8'h55, 8'hAA, 8'hFA, 8'hF5, 8'h0F};
    vec_exp  = '{0,     8,     1,     1,     4,     4,     6,     6,     4};

    $display("[TB] reset with all-ones input");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 8'hFF, 0, "reset_hold");
    applyStimulus(1'b0, 8'hFF, 8, "reset_release");

    $display("[TB] extremes and patterns");
    for (int k = 0; k < 9; k++) applyStimulus(1'b0, vec_data[k], vec_exp[k], "pattern");

    $display("[TB] back-to-back toggling");
    applyStimulus(1'b0, 8'h00, 0, "b2b");
    applyStimulus(1'b0, 8'hFF, 8, "b2b");
    applyStimulus(1'b0, 8'h00, 0, "b2b");
    applyStimulus(1'b0, 8'hFF, 8, "b2b");

    $display("[TB] decrement sweep with a reset pulse");
    sweep = 8'hFF;
    for (int k = 0; k <= 51; k++) begin
      if (k == 20) begin
        applyStimulus(1'b1, sweep, 0, "sweep_reset");
      end else begin
        applyStimulus(1'b0, sweep, ref_pop(sweep), "sweep");
      end
      sweep = sweep - 8'd5;
    end
    applyStimulus(1'b0, 8'h00, 0, "sweep_final");

    // Let the monitor consume everything still queued, bounded in cycles
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge i_clk);
      #2;
      drain++;
    end
    if (exp_q.size() > 0) begin
      bad_checks++;
      $display("[TB] FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
